ac97_frame_tx: RTL and testbench

- AC'97 output-link serializer. Sits between the audio sample/command sources inside `main` and the codec pins `AC97_SDATA_OUT` and `AC97_SYNC`.
- Builds continuous 256-bit AC'97 frames clocked by the codec bit clock: slot0 tag, slot1/2 register command, slot3/4 PCM left/right.
- Accepts PCM samples and codec register commands through valid/ready handshakes.
- Reports frame boundaries and sample underruns.

---
 rtl/ac97_frame_tx.sv | 189 ++++++++++++++++++
 tb/tb_ac97_frame_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac97_frame_tx.sv
// AC'97 output-link serializer: builds 256-bit frames (tag, command, PCM L/R) on the codec bit clock.
// Optional build macro AC97_REPEAT_SAMPLE_EN resends the last sample pair on a PCM underrun.
module ac97_frame_tx #(
  parameter int unsigned STARTUP_FRAMES = 4,
  parameter logic [1:0]  CODEC_ID       = 2'b00
) (
  input  logic        ac97_bit_clock,
  input  logic        SYS_RST_N,
  input  logic [19:0] pcm_left,
  input  logic [19:0] pcm_right,
  input  logic        pcm_valid,
  output logic        pcm_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        ac97_sdata_out,
  output logic        ac97_synch,
  output logic        frame_start,
  output logic [7:0]  underrun_count
);

  localparam logic [7:0] STARTUP_LIMIT = 8'(STARTUP_FRAMES);

  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  startup_q, startup_d;
  logic [7:0]  underrun_q, underrun_d;
  logic        sdata_q, sdata_d;
  logic        synch_q, synch_d;
  logic        fs_q, fs_d;
  logic [94:0] shift_q, shift_d;

  logic        pcm_full_q, pcm_full_d;
  logic [19:0] pcm_left_q, pcm_left_d;
  logic [19:0] pcm_right_q, pcm_right_d;
  logic        cmd_full_q, cmd_full_d;
  logic        cmd_rw_q, cmd_rw_d;
  logic [6:0]  cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;
`ifdef AC97_REPEAT_SAMPLE_EN
  logic [19:0] last_left_q, last_left_d;
  logic [19:0] last_right_q, last_right_d;
`endif

  logic        wrap, in_startup, consume, pcm_accept, cmd_accept;
  logic [15:0] tag;
  logic [19:0] slot1, slot2, slot3, slot4;
  logic [95:0] frame_w;

  assign wrap       = (bit_cnt_q == 8'd255);
  assign in_startup = (startup_q < STARTUP_LIMIT);
  assign consume    = wrap & ~in_startup;
  assign pcm_accept = pcm_valid & ~pcm_full_q;
  assign cmd_accept = cmd_valid & ~cmd_full_q;

  // Frame snapshot built from holding-register state as it stands before the wrap edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    tag   = '0;
    slot1 = '0;
    slot2 = '0;
    slot3 = '0;
    slot4 = '0;
    if (!in_startup) begin
      tag[15]  = 1'b1;
      tag[1:0] = CODEC_ID;
      if (cmd_full_q) begin
        tag[14] = 1'b1;
        tag[13] = ~cmd_rw_q;
        slot1   = {cmd_rw_q, cmd_addr_q, 12'h000};
        slot2   = cmd_rw_q ? 20'h0 : {cmd_data_q, 4'h0};
      end
      if (pcm_full_q) begin
        tag[12:11] = 2'b11;
        slot3      = pcm_left_q;
        slot4      = pcm_right_q;
      end
`ifdef AC97_REPEAT_SAMPLE_EN
      else begin
        tag[12:11] = 2'b11;
        slot3      = last_left_q;
        slot4      = last_right_q;
      end
`endif
    end
    frame_w = {tag, slot1, slot2, slot3, slot4};
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q + 8'd1;
    synch_d     = (bit_cnt_d < 8'd16);
    fs_d        = (bit_cnt_d == 8'd0);
    sdata_d     = shift_q[94];
    shift_d     = {shift_q[93:0], 1'b0};
    startup_d   = startup_q;
    underrun_d  = underrun_q;
    pcm_full_d  = pcm_full_q;
    pcm_left_d  = pcm_left_q;
    pcm_right_d = pcm_right_q;
    cmd_full_d  = cmd_full_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
`ifdef AC97_REPEAT_SAMPLE_EN
    last_left_d  = last_left_q;
    last_right_d = last_right_q;
    if (consume && pcm_full_q) begin
      last_left_d  = pcm_left_q;
      last_right_d = pcm_right_q;
    end
`endif
    // Bit 0 goes straight out of the new snapshot; bits 1..95 follow from the shifter.
    if (wrap) begin
      sdata_d = frame_w[95];
      shift_d = frame_w[94:0];
    end
    if (wrap && in_startup) startup_d = startup_q + 8'd1;
    if (consume && !pcm_full_q && underrun_q != 8'hFF) underrun_d = underrun_q + 8'd1;

    // An accept only happens into an empty register, so it never collides with a consume.
    if (pcm_accept) begin
      pcm_full_d  = 1'b1;
      pcm_left_d  = pcm_left;
      pcm_right_d = pcm_right;
    end else if (consume) begin
      pcm_full_d = 1'b0;
    end
    if (cmd_accept) begin
      cmd_full_d = 1'b1;
      cmd_rw_d   = cmd_rw;
      cmd_addr_d = cmd_addr;
      cmd_data_d = cmd_data;
    end else if (consume) begin
      cmd_full_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ac97_bit_clock or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      bit_cnt_q   <= 8'd255;
      startup_q   <= '0;
      underrun_q  <= '0;
      sdata_q     <= 1'b0;
      synch_q     <= 1'b0;
      fs_q        <= 1'b0;
      shift_q     <= '0;
      pcm_full_q  <= 1'b0;
      pcm_left_q  <= '0;
      pcm_right_q <= '0;
      cmd_full_q  <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
`ifdef AC97_REPEAT_SAMPLE_EN
      last_left_q  <= '0;
      last_right_q <= '0;
`endif
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      startup_q   <= startup_d;
      underrun_q  <= underrun_d;
      sdata_q     <= sdata_d;
      synch_q     <= synch_d;
      fs_q        <= fs_d;
      shift_q     <= shift_d;
      pcm_full_q  <= pcm_full_d;
      pcm_left_q  <= pcm_left_d;
      pcm_right_q <= pcm_right_d;
      cmd_full_q  <= cmd_full_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
`ifdef AC97_REPEAT_SAMPLE_EN
      last_left_q  <= last_left_d;
      last_right_q <= last_right_d;
`endif
    end
  end

  assign ac97_sdata_out = sdata_q;
  assign ac97_synch     = synch_q;
  assign frame_start    = fs_q;
  assign underrun_count = underrun_q;
  assign pcm_ready      = ~pcm_full_q;
  assign cmd_ready      = ~cmd_full_q;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Self-checking bench for ac97_frame_tx: a frame-level reference model predicts every frame,
// directed and randomized PCM/command traffic is compared bit-for-bit against the serial output.
module tb_ac97_frame_tx;

  localparam int         STARTUP = 4;
  localparam logic [1:0] CID     = 2'b00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] pcm_left = '0, pcm_right = '0;
  logic        pcm_valid = 1'b0;
  logic        cmd_rw = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_valid = 1'b0;
  logic        pcm_ready, cmd_ready, ac97_sdata_out, ac97_synch, frame_start;
  logic [7:0]  underrun_count;

  always #5 clk = ~clk;

  ac97_frame_tx #(.STARTUP_FRAMES(STARTUP), .CODEC_ID(CID)) dut (
    .ac97_bit_clock(clk), .SYS_RST_N(rst_n),
    .pcm_left(pcm_left), .pcm_right(pcm_right), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .ac97_sdata_out(ac97_sdata_out), .ac97_synch(ac97_synch),
    .frame_start(frame_start), .underrun_count(underrun_count)
  );

  int n_pass = 0;
  int n_total = 0;

  // Frame-level reference model: pending items, frames since reset, expected next frame.
  int           edges;
  int           m_frames;
  logic         m_pcm_pend, m_cmd_pend, m_rw;
  logic [19:0]  m_l, m_r, m_last_l, m_last_r;
  logic [6:0]   m_addr;
  logic [15:0]  m_data;
  logic [7:0]   m_uc;
  logic [0:255] exp_bits;

  always @(posedge clk or negedge rst_n) begin : model_p
    logic [15:0] t;
    logic [19:0] s1, s2, s3, s4;
    logic        pv;
    if (!rst_n) begin
      edges <= 0; m_frames <= 0; m_pcm_pend <= 0; m_cmd_pend <= 0; m_uc <= 0;
      m_last_l <= 0; m_last_r <= 0; exp_bits <= '0;
    end else begin
      edges <= edges + 1;
      if (edges % 256 == 0) begin
        if (m_frames < STARTUP) begin
          exp_bits <= '0;
          m_frames <= m_frames + 1;
        end else begin
          pv = m_pcm_pend;
          s3 = m_pcm_pend ? m_l : 20'h0;
          s4 = m_pcm_pend ? m_r : 20'h0;
`ifdef AC97_REPEAT_SAMPLE_EN
          if (!m_pcm_pend) begin pv = 1'b1; s3 = m_last_l; s4 = m_last_r; end
`endif
          if (m_pcm_pend) begin m_last_l <= m_l; m_last_r <= m_r; end
          else if (m_uc != 8'd255) m_uc <= m_uc + 8'd1;
          s1 = m_cmd_pend ? {m_rw, m_addr, 12'h000} : 20'h0;
          s2 = (m_cmd_pend && !m_rw) ? {m_data, 4'h0} : 20'h0;
          t  = {1'b1, m_cmd_pend, m_cmd_pend & ~m_rw, pv, pv, 9'd0, CID};
          exp_bits   <= {t, s1, s2, s3, s4, 160'd0};
          m_pcm_pend <= 1'b0;
          m_cmd_pend <= 1'b0;
        end
      end
      if (pcm_valid && !m_pcm_pend) begin m_pcm_pend <= 1'b1; m_l <= pcm_left; m_r <= pcm_right; end
      if (cmd_valid && !m_cmd_pend) begin
        m_cmd_pend <= 1'b1; m_rw <= cmd_rw; m_addr <= cmd_addr; m_data <= cmd_data;
      end
    end
  end

  function automatic int cur_bit();
    return (edges == 0) ? -1 : ((edges - 1) % 256);
  endfunction

  task automatic wait_bit(input int n);
    int budget = 600;
    do begin
      @(negedge clk);
      budget--;
    end while (cur_bit() != n && budget > 0);
    if (cur_bit() != n) begin
      n_total++;
      $display("FAIL wait_bit timeout got=%0d want=%0d", cur_bit(), n);
    end
  endtask

  task automatic capture_frame(output logic [0:255] got, output logic [0:255] exp,
                               output int sync_bad, output int fs_bad,
                               output logic [7:0] uc, output logic [7:0] exp_uc,
                               output logic prdy, output logic crdy);
    wait_bit(0);
    exp = exp_bits; exp_uc = m_uc; uc = underrun_count; prdy = pcm_ready; crdy = cmd_ready;
    sync_bad = 0; fs_bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      got[i] = ac97_sdata_out;
      if (ac97_synch !== ((i < 16) ? 1'b1 : 1'b0)) sync_bad++;
      if (frame_start !== ((i == 0) ? 1'b1 : 1'b0)) fs_bad++;
    end
  endtask

  task automatic offer_pcm(input int k, input logic [19:0] l, input logic [19:0] r);
    wait_bit(k);
    pcm_left = l; pcm_right = r; pcm_valid = 1'b1;
    @(negedge clk);
    pcm_valid = 1'b0;
    n_total++;
    if (pcm_ready !== 1'b0) $display("FAIL pcm_ready_drop got=%b exp=0", pcm_ready); else n_pass++;
  endtask

  task automatic offer_cmd(input int k, input logic rw, input logic [6:0] a, input logic [15:0] d);
    wait_bit(k);
    cmd_rw = rw; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_total++;
    if (cmd_ready !== 1'b0) $display("FAIL cmd_ready_drop got=%b exp=0", cmd_ready); else n_pass++;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_total++;
    if ({ac97_sdata_out, ac97_synch, frame_start} !== 3'b000)
      $display("FAIL %s_serial got=%b exp=000", tag, {ac97_sdata_out, ac97_synch, frame_start});
    else n_pass++;
    n_total++;
    if ({pcm_ready, cmd_ready} !== 2'b11)
      $display("FAIL %s_ready got=%b exp=11", tag, {pcm_ready, cmd_ready});
    else n_pass++;
    n_total++;
    if (underrun_count !== 8'd0) $display("FAIL %s_underrun got=%0d exp=0", tag, underrun_count);
    else n_pass++;
  endtask

  logic [0:255] got, exp;
  int           sb, fb;
  logic [7:0]   uc, euc;
  logic         prdy, crdy;

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_startup();
    for (int f = 0; f < STARTUP; f++) begin
      capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
      n_total++;
      if (got !== 256'd0) $display("FAIL startup_data f=%0d got=%h exp=0", f, got); else n_pass++;
      n_total++;
      if (sb !== 0) $display("FAIL startup_synch f=%0d bad_bits=%0d exp=0", f, sb); else n_pass++;
      n_total++;
      if (fb !== 0) $display("FAIL startup_frame_start f=%0d bad_bits=%0d exp=0", f, fb); else n_pass++;
    end
    capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
    n_total++;
    if (got[0:15] !== 16'h8000) $display("FAIL first_tag got=%h exp=8000", got[0:15]); else n_pass++;
    n_total++;
    if (uc !== 8'd1) $display("FAIL first_underrun got=%0d exp=1", uc); else n_pass++;
    n_total++;
    if (fb !== 0 || sb !== 0) $display("FAIL first_framing got=%0d/%0d exp=0/0", sb, fb); else n_pass++;
  endtask

  task automatic test_pcm();
    offer_pcm(100, 20'hABCDE, 20'h12345);
    capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
    n_total++;
    if (got[0:15] !== 16'h9800) $display("FAIL pcm_tag got=%h exp=9800", got[0:15]); else n_pass++;
    n_total++;
    if ({got[56:75], got[76:95]} !== {20'hABCDE, 20'h12345})
      $display("FAIL pcm_slots got=%h exp=abcde12345", {got[56:75], got[76:95]});
    else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL pcm_frame got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    if (prdy !== 1'b1) $display("FAIL pcm_ready_after_wrap got=%b exp=1", prdy); else n_pass++;
  endtask

  task automatic test_cmd();
    offer_cmd(30, 1'b0, 7'h02, 16'h0808);
    capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
    n_total++;
    if ({got[1:2], got[16:35], got[36:55]} !== {2'b11, 20'h02000, 20'h08080})
      $display("FAIL cmd_write got=%h exp=%h", {got[1:2], got[16:35], got[36:55]},
               {2'b11, 20'h02000, 20'h08080});
    else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL cmd_write_frame got=%h exp=%h", got, exp); else n_pass++;
    capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
    n_total++;
    if (got[1:2] !== 2'b00) $display("FAIL cmd_once got=%b exp=00", got[1:2]); else n_pass++;
    n_total++;
    if (uc !== euc) $display("FAIL cmd_underrun got=%0d exp=%0d", uc, euc); else n_pass++;
    offer_cmd(200, 1'b1, 7'h26, 16'(($urandom)));
    capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
    n_total++;
    if ({got[1:2], got[16:35], got[36:55]} !== {2'b10, 20'hA6000, 20'h00000})
      $display("FAIL cmd_read got=%h exp=%h", {got[1:2], got[16:35], got[36:55]},
               {2'b10, 20'hA6000, 20'h00000});
    else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL cmd_read_frame got=%h exp=%h", got, exp); else n_pass++;
  endtask

  task automatic test_wrap_edge();
    logic [19:0] l, r;
    l = 20'($urandom); r = 20'($urandom);
    wait_bit(255);
    pcm_left = l; pcm_right = r; pcm_valid = 1'b1;
    fork
      capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
      begin @(negedge clk); pcm_valid = 1'b0; end
    join
`ifndef AC97_REPEAT_SAMPLE_EN
    n_total++;
    if (got[3] !== 1'b0) $display("FAIL wrap_tag12 got=%b exp=0", got[3]); else n_pass++;
`endif
    n_total++;
    if (uc !== euc) $display("FAIL wrap_underrun got=%0d exp=%0d", uc, euc); else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL wrap_frame got=%h exp=%h", got, exp); else n_pass++;
    capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
    n_total++;
    if ({got[3], got[56:75], got[76:95]} !== {1'b1, l, r})
      $display("FAIL wrap_next got=%h exp=%h", {got[3], got[56:75], got[76:95]}, {1'b1, l, r});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(3) != 0)
        offer_pcm(int'($urandom_range(120, 1)), 20'($urandom), 20'($urandom));
      if ($urandom_range(1) != 0)
        offer_cmd(int'($urandom_range(250, 130)), 1'($urandom), 7'($urandom), 16'($urandom));
      capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
      n_total++;
      if (got !== exp) $display("FAIL rand_frame it=%0d got=%h exp=%h", it, got, exp); else n_pass++;
      n_total++;
      if (uc !== euc) $display("FAIL rand_underrun it=%0d got=%0d exp=%0d", it, uc, euc); else n_pass++;
    end
  endtask

  task automatic test_saturation_and_reset();
    repeat (300 * 256) @(negedge clk);
    n_total++;
    if (underrun_count !== 8'd255) $display("FAIL underrun_sat got=%0d exp=255", underrun_count);
    else n_pass++;
    n_total++;
    if (underrun_count !== m_uc) $display("FAIL underrun_model got=%0d exp=%0d", underrun_count, m_uc);
    else n_pass++;
    offer_cmd(20, 1'b0, 7'h11, 16'hBEEF);
    offer_pcm(25, 20'h11111, 20'h22222);
    wait_bit(40);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < STARTUP; f++) capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
    capture_frame(got, exp, sb, fb, uc, euc, prdy, crdy);
    n_total++;
    if (got[0:15] !== 16'h8000) $display("FAIL restart_tag got=%h exp=8000", got[0:15]); else n_pass++;
    n_total++;
    if (got !== exp) $display("FAIL restart_frame got=%h exp=%h", got, exp); else n_pass++;
    n_total++;
    if (uc !== 8'd1) $display("FAIL restart_underrun got=%0d exp=1", uc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_pcm();
    test_cmd();
    test_wrap_edge();
    test_random();
    test_saturation_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
